// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the byte-serial memory arbiter: LSB op field layout,
// size codes and byte counts, IO window base, and FSM state encoding.
package mem_arbiter_pkg;

  localparam int OP_STORE_BIT    = 3;
  localparam int OP_UNSIGNED_BIT = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [2:0] NB_BYTE = 3'd1;
  localparam logic [2:0] NB_HALF = 3'd2;
  localparam logic [2:0] NB_WORD = 3'd4;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IF  = 1'b0,
    SRC_LSB = 1'b1
  } src_t;

  // Number of bus bytes for an LSB size code; unknown codes behave as word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SZ_BYTE: return NB_BYTE;
      SZ_HALF: return NB_HALF;
      default: return NB_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-wide external RAM/IO port arbiter. LSB commit-time accesses have
// fixed priority over instruction fetch; every access is sequenced as
// consecutive single-byte bus cycles.
//
// Build option: MEM_ARB_IO_STALL_EN -- when defined, write bytes aimed at
// addresses >= IO_BASE wait while io_buffer_full is high.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | bus idle, sampling requests (LSB wins over fetch)
// ST_READ  | issuing addresses and capturing mem_din one byte per cycle
// ST_WRITE | driving one write byte per cycle
// ST_GUARD | done pulse cycle; requester still holds valid, so no accept
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT[ADDR_W-1:0]
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_flag,
  input  logic              if_valid,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_valid,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  input  logic [3:0]        lsb_op,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_t            state;
  src_t              src_q;
  logic [ADDR_W-1:0] base_q;
  logic [2:0]        op_q;
  logic [31:0]       wdata_q;
  logic [2:0]        n_q;
  logic [2:0]        cnt_q;
  logic [31:0]       asm_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic [7:0]        mem_dout_q;
  logic              mem_wr_q;
  logic              if_done_q;
  logic [31:0]       if_data_q;
  logic              lsb_done_q;
  logic [31:0]       lsb_rdata_q;

  logic [3:0]        step;
  logic [3:0]        n_ext;
  logic [ADDR_W-1:0] next_addr;
  logic              is_io;
  logic              io_stall;

  // Sign- or zero-extend the assembled load; words pass through unchanged.
  function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [2:0] op);
    case (op[1:0])
      SZ_BYTE: return op[OP_UNSIGNED_BIT] ? {24'b0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: return op[OP_UNSIGNED_BIT] ? {16'b0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  assign step      = {1'b0, cnt_q} + 4'd1;
  assign n_ext     = {1'b0, n_q};
  assign next_addr = base_q + {{(ADDR_W-4){1'b0}}, step};
  assign is_io     = (mem_a_q >= IO_BASE);

`ifdef MEM_ARB_IO_STALL_EN
  assign io_stall = (state == ST_WRITE) && mem_wr_q && is_io && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = &{1'b0, io_buffer_full, is_io};
  assign io_stall  = 1'b0;
`endif

  // Gating with rdy_in keeps a paused write byte from being issued twice.
  assign mem_wr    = mem_wr_q & rdy_in & ~io_stall;
  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

  // Arbitration FSM with registered bus and result outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state       <= ST_IDLE;
      src_q       <= SRC_IF;
      base_q      <= '0;
      op_q        <= '0;
      wdata_q     <= '0;
      n_q         <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      mem_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      lsb_done_q  <= 1'b0;
      lsb_rdata_q <= '0;
    end else if (rdy_in) begin
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!clear_flag && (lsb_valid || if_valid)) begin
            cnt_q <= '0;
            asm_q <= '0;
            if (lsb_valid) begin
              src_q   <= SRC_LSB;
              base_q  <= lsb_addr;
              op_q    <= lsb_op[2:0];
              wdata_q <= lsb_wdata;
              n_q     <= size_to_n(lsb_op[1:0]);
              mem_a_q <= lsb_addr;
              if (lsb_op[OP_STORE_BIT]) begin
                state      <= ST_WRITE;
                mem_wr_q   <= 1'b1;
                mem_dout_q <= lsb_wdata[7:0];
              end else begin
                state <= ST_READ;
              end
            end else begin
              src_q   <= SRC_IF;
              base_q  <= if_addr;
              op_q    <= {1'b0, SZ_WORD};
              n_q     <= NB_WORD;
              mem_a_q <= if_addr;
              state   <= ST_READ;
            end
          end
        end

        ST_READ: begin
          if (clear_flag && src_q == SRC_IF) begin
            state   <= ST_IDLE;
            mem_a_q <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + 3'd1;
            mem_a_q <= (step < n_ext) ? next_addr : '0;
            // Data for the address issued two edges ago is on mem_din now.
            if (cnt_q != 3'd0 && cnt_q <= n_q) begin
              case (cnt_q)
                3'd1:    asm_q[7:0]   <= mem_din;
                3'd2:    asm_q[15:8]  <= mem_din;
                3'd3:    asm_q[23:16] <= mem_din;
                default: asm_q[31:24] <= mem_din;
              endcase
            end
            if (step == n_ext + 4'd2) begin
              state <= ST_GUARD;
              cnt_q <= '0;
              if (src_q == SRC_IF) begin
                if_done_q <= 1'b1;
                if_data_q <= asm_q;
              end else begin
                lsb_done_q  <= 1'b1;
                lsb_rdata_q <= extend_load(asm_q, op_q);
              end
            end
          end
        end

        ST_WRITE: begin
          if (!io_stall) begin
            if (step < n_ext) begin
              cnt_q      <= cnt_q + 3'd1;
              mem_a_q    <= next_addr;
              mem_dout_q <= wdata_q[8*step[1:0] +: 8];
            end else begin
              state       <= ST_GUARD;
              cnt_q       <= '0;
              mem_wr_q    <= 1'b0;
              mem_a_q     <= '0;
              mem_dout_q  <= '0;
              lsb_done_q  <= 1'b1;
              lsb_rdata_q <= '0;
            end
          end
        end

        ST_GUARD: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the byte-wide external RAM/IO port.
- Arbitrates between instruction fetch (32-bit word reads) and LSB commit-time loads/stores (byte/half/word).
- Sequences each access as consecutive single-byte bus cycles, assembles or extends the read data, and returns a one-cycle done pulse to the winning requester.
- Sits between the IF unit, the LSB and the top-level memory pins.

Parameters:
- ADDR_W, 32, address width of all address ports.
- IO_BASE, 32'h0003_0000, lowest IO-mapped address; used only by the optional feature.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous reset, active-low
- rdy_in  in  1  global pause when low
- clear_flag  in  1  pipeline flush (branch mispredict)
- if_valid  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch address, word-aligned
- if_done  out  1  one-cycle pulse: if_data valid
- if_data  out  32  fetched word, little-endian
- lsb_valid  in  1  LSB request, level (LSB full_mem)
- lsb_addr  in  ADDR_W  access address
- lsb_wdata  in  32  store data; low bytes used
- lsb_op  in  4  op[3]=1 store / 0 load; op[2]=1 zero-extend load; op[1:0] 00 byte, 01 half, 10 word
- lsb_done  out  1  one-cycle pulse: load data valid or store complete
- lsb_rdata  out  32  extended load result; 0 after a store
- mem_din  in  8  RAM read byte, valid one cycle after mem_a
- mem_dout  out  8  RAM write byte
- mem_a  out  ADDR_W  RAM byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  UART TX buffer full

Behaviour:
- Reset (rst_in low at clk edge): state IDLE; all outputs 0; byte counter and assembly register cleared. Overrides rdy_in and clear_flag.
- rdy_in low:
  - All registers hold.
  - mem_wr is forced to 0 combinationally, so each write byte is issued exactly once.
- States:
  - IDLE: sample requests.
  - READ: byte-serial read.
  - WRITE: byte-serial write.
  - GUARD: one cycle.
- Arbitration in IDLE: lsb_valid beats if_valid (fixed priority). The winner is latched: source, addr, op, wdata, byte count n (1/2/4; fetch n=4).
- READ:
  - mem_a = base+k for k = 0..n-1, one byte per cycle, starting the cycle after acceptance.
  - Byte k is captured from mem_din one cycle later into bits [8k+7:8k].
  - Done pulses the cycle after byte n-1 is captured.
  - Total: word read done 6 cycles after the accepting edge; byte read done 3 cycles after.
- WRITE:
  - mem_wr=1, mem_a=base+k, mem_dout=wdata[8k+7:8k] for k = 0..n-1.
  - lsb_done pulses the cycle after the last byte.
- Load extension: sign-extend from bit 7 or 15 unless op[2]=1 (then zero-extend). Word loads are passed through unchanged.
- Done cycle → GUARD:
  - Requesters drop valid one cycle after seeing done, so GUARD accepts no request.
  - GUARD → IDLE.
- Idle bus: mem_wr=0, mem_a=0, mem_dout=0. if_data and lsb_rdata hold their last value.
- clear_flag, fetch in flight: abort; no if_done; next state IDLE (no GUARD needed, IF drops valid on flush).
- clear_flag, LSB access in flight: LSB accesses are committed. They run to completion, and lsb_done still pulses (LSB ignores it).
- clear_flag in IDLE: no acceptance that cycle.
- Unaligned addresses: bytes go to consecutive addresses; no fault.

Optional Feature:
- Macro: MEM_ARB_IO_STALL_EN.
- Defined:
  - A WRITE byte with address ≥ IO_BASE stalls while io_buffer_full=1: mem_wr=0, counter holds.
  - It resumes the cycle after io_buffer_full drops.
  - IO reads are never speculative, because only the LSB reaches IO.
- Undefined: io_buffer_full is ignored; IO writes proceed unconditionally.

Decomposition:
- Shared const.v gets:
  - LSB op field encodings: store bit, unsigned bit, size codes.
  - Size-to-byte-count constants.
  - IO_BASE default.
  - State encodings for IDLE/READ/WRITE/GUARD.
- No sub-module required. The load extension is a combinational function inside the block.

Test Plan:
- Word fetch if_addr=0x100, RAM 0x100..0x103 = 13 00 00 00 → if_done 6 cycles after acceptance, if_data=0x00000013, mem_wr never 1.
- Both valid in same IDLE cycle: LSB lb 0x200 (RAM=0x80), fetch 0x0 → LSB served first, lsb_rdata=0xFFFFFF80; fetch accepted only after GUARD.
- Same with op=lbu → lsb_rdata=0x00000080. lh at 0x204 with bytes 34 F2 → 0xFFFFF234.
- sw 0xDEADBEEF at 0x300 → mem_wr=1 on 4 consecutive cycles, bytes EF BE AD DE at 0x300..0x303; lsb_done one pulse; rdy_in low mid-write → no duplicate or skipped byte.
- clear_flag on 2nd byte of a fetch → no if_done, IDLE next cycle; clear_flag during a sb → write completes, lsb_done pulses.
- MEM_ARB_IO_STALL_EN: sb 0x41 to 0x30000 with io_buffer_full=1 for 5 cycles → mem_wr=0 for those cycles, then one write of 0x41, then lsb_done.
